// File: rtl/memory_arbiter.sv
// memory_arbiter
// Serialises instruction-fetch and data accesses onto the single-ported unified RAM.
// Data accesses win arbitration, except when an instruction request has been kept
// waiting through STARVE_MAX data completions; then the instruction side goes first.
//
// Ports:
//   CLK, nRST                 clock (rising edge), asynchronous active-low reset
//   iREN, iaddr               instruction read request / address (held until iwait=0)
//   iload, iwait              instruction read data / wait (0 only in completing cycle)
//   dREN, dWEN, daddr, dstore data read/write request, address, write value
//   dload, dwait              data read value / wait (0 only in completing cycle)
//   ramREN, ramWEN            RAM read/write strobes
//   ramaddr, ramstore         RAM address / write data
//   ramload, ramstate         RAM read data / status (0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR)
module memory_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [3:0] C_STARVE   = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIacc, StDacc} state_e;

  state_e     r_state;
  logic [3:0] r_scnt;

  logic w_dreq;
  logic w_access;
  logic w_starved;

  assign w_dreq    = dREN | dWEN;
  assign w_access  = (ramstate == RAM_ACCESS);
  assign w_starved = iREN && (r_scnt == C_STARVE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= StIdle;
      r_scnt  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (!iREN) r_scnt <= '0;
          if (w_dreq && !w_starved) r_state <= StDacc;
          else if (iREN)            r_state <= StIacc;
        end
        StIacc: begin
          // Completion wins over a same-cycle drop of iREN.
          if (w_access) begin
            r_state <= StIdle;
            r_scnt  <= '0;
          end else if (!iREN) begin
            r_state <= StIdle;
          end
        end
        StDacc: begin
          if (w_access) begin
            r_state <= StIdle;
            if (!iREN)                   r_scnt <= '0;
            else if (r_scnt >= C_STARVE) r_scnt <= C_STARVE;
            else                         r_scnt <= r_scnt + 4'd1;
          end else if (!w_dreq) begin
            // Abort leaves the starvation count untouched.
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Strobes and waits follow the registered state directly, so an asynchronous
  // reset drops them immediately.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (r_state)
      StIacc: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iload   = ramload;
        iwait   = ~w_access;
      end
      StDacc: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dload    = ramload;
        dwait    = ~w_access;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  localparam int unsigned StarveMax = 4;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  memory_arbiter #(.STARVE_MAX(StarveMax)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .iwait    (iwait),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  int    checks = 0;
  int    errors = 0;
  exp_t  iexp[$];
  exp_t  dexp[$];
  string glog = "";
  int    sc   = 0;

  // Reference data memory (updated in program order at issue) and RAM contents.
  logic [31:0] dref[logic [31:0]];
  logic [31:0] mem[logic [31:0]];

  int fixed_lat = 1;
  bit force_err = 0;

  function automatic logic [31:0] ival(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic issue_i(input logic [31:0] a, input logic [31:0] e);
    exp_t x;
    iaddr = a;
    iREN  = 1'b1;
    x.wr = 1'b0; x.addr = a; x.data = e;
    iexp.push_back(x);
  endtask

  task automatic issue_d(input bit wr, input logic [31:0] a, input logic [31:0] v,
                         input bit rd_too, input bit push);
    exp_t x;
    dWEN   = wr;
    dREN   = wr ? rd_too : 1'b1;
    daddr  = a;
    dstore = v;
    x.wr = wr; x.addr = a;
    if (wr) begin
      if (push) dref[a] = v;
      x.data = v;
    end else begin
      x.data = dref.exists(a) ? dref[a] : ival(a);
    end
    if (push) dexp.push_back(x);
  endtask

  task automatic wait_done(input bit is_d);
    bit done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge CLK);
      if (is_d ? !dwait : !iwait) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: wait still 1 after 300 cycles, expected 0", is_d ? "d" : "i");
    end
    step();
  endtask

  // RAM model: latency chosen per access, ERROR optionally reported instead of BUSY.
  initial begin : ram_model
    int ram_cnt;
    bit ram_active;
    bit ram_err;
    ram_cnt = 0; ram_active = 0; ram_err = 0;
    ramstate = 2'd0;
    ramload  = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (nRST && (ramREN || ramWEN)) begin
        if (!ram_active) begin
          ram_active = 1;
          ram_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          ram_err = force_err || (fixed_lat < 0 && $urandom_range(0, 3) == 0);
        end
        if (ram_cnt == 0) begin
          ramstate = 2'd2;
          if (ramWEN) begin
            mem[ramaddr] = ramstore;
            ramload = $urandom;
          end else begin
            ramload = mem.exists(ramaddr) ? mem[ramaddr] : ival(ramaddr);
          end
        end else begin
          ramstate = ram_err ? 2'd3 : 2'd1;
          ram_cnt--;
          ramload = $urandom;
        end
      end else begin
        ram_active = 0;
        ramstate = 2'd0;
        ramload = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a side completes.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (nRST) begin
        if (!iwait) begin
          glog = {glog, "I"};
          sc = 0;
          if (iexp.size() == 0) begin
            checks++; errors++;
            $display("FAIL i_unexpected: iwait=0 with no request outstanding, addr %h", ramaddr);
          end else begin
            e = iexp.pop_front();
            chk("iload", iload, e.data);
            chk("i_ramaddr", ramaddr, e.addr);
            chk("i_ramREN", 32'(ramREN), 32'd1);
          end
        end
        if (!dwait) begin
          glog = {glog, "D"};
          if (iREN) sc++;
          chk("starve_bound", 32'(sc <= StarveMax), 32'd1);
          if (dexp.size() == 0) begin
            checks++; errors++;
            $display("FAIL d_unexpected: dwait=0 with no request outstanding, addr %h", ramaddr);
          end else begin
            e = dexp.pop_front();
            chk("d_ramaddr", ramaddr, e.addr);
            if (e.wr) begin
              chk("d_ramWEN", 32'(ramWEN), 32'd1);
              chk("d_ramREN_wr", 32'(ramREN), 32'd0);
              chk("d_ramstore", ramstore, e.data);
            end else begin
              chk("dload", dload, e.data);
              chk("d_ramREN", 32'(ramREN), 32'd1);
            end
          end
        end
        if (!iREN) sc = 0;
        if (!ramREN) chk("iload_zero", iload, 32'd0);
      end
    end
  end

  initial begin : stim
    nRST = 0; iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
    mem[32'h40] = 32'h8C22_0004;

    // Reset with both sides requesting; data must win the first grant.
    iREN = 1; iaddr = 32'h2000; dWEN = 1; daddr = 32'h1000; dstore = 32'h1111_1111;
    repeat (2) @(negedge CLK);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_iload", iload, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    issue_i(32'h2000, ival(32'h2000));
    issue_d(1'b1, 32'h1000, 32'h1111_1111, 1'b0, 1'b1);
    step();
    nRST = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("first_grant_d", 32'(ramWEN), 32'd1);
    wait_done(1'b1);
    dWEN = 0;
    wait_done(1'b0);
    iREN = 0;

    // Instruction read, two BUSY cycles then ACCESS.
    fixed_lat = 2;
    issue_i(32'h40, 32'h8C22_0004);
    @(negedge CLK);
    chk("i_c0_ramREN", 32'(ramREN), 32'd0);
    @(negedge CLK);
    chk("i_c1_ramREN", 32'(ramREN), 32'd1);
    chk("i_c1_ramaddr", ramaddr, 32'h40);
    chk("i_c1_iwait", 32'(iwait), 32'd1);
    @(negedge CLK);
    chk("i_c2_iwait", 32'(iwait), 32'd1);
    @(negedge CLK);
    chk("i_c3_iwait", 32'(iwait), 32'd0);
    chk("i_c3_iload", iload, 32'h8C22_0004);
    step();
    iREN = 0;
    @(negedge CLK);
    chk("i_c4_ramREN", 32'(ramREN), 32'd0);
    step();

    // Data write with dREN also high: write wins.
    fixed_lat = 1;
    issue_d(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    chk("w_ramWEN", 32'(ramWEN), 32'd1);
    chk("w_ramREN", 32'(ramREN), 32'd0);
    chk("w_ramstore", ramstore, 32'hDEAD_BEEF);
    chk("w_ramaddr", ramaddr, 32'h100);
    chk("w_dwait_busy", 32'(dwait), 32'd1);
    @(negedge CLK);
    chk("w_dwait_done", 32'(dwait), 32'd0);
    step();
    dWEN = 0; dREN = 0;
    issue_d(1'b0, 32'h100, $urandom, 1'b0, 1'b1);
    wait_done(1'b1);
    dREN = 0;

    // Starvation: iREN held across five back-to-back data reads.
    glog = "";
    fork
      begin
        issue_i(32'h2040, ival(32'h2040));
        wait_done(1'b0);
        iREN = 0;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          issue_d(1'b0, 32'h1000 + 32'(4 * k), $urandom, 1'b0, 1'b1);
          wait_done(1'b1);
        end
        dREN = 0;
      end
    join
    checks++;
    if (glog != "DDDDID") begin
      errors++;
      $display("FAIL starve_order: got %s, expected DDDDID", glog);
    end

    // Abort: data read dropped while BUSY, pending instruction granted after IDLE.
    fixed_lat = 3;
    issue_i(32'h2080, ival(32'h2080));
    issue_d(1'b0, 32'h104, $urandom, 1'b0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_dgrant", ramaddr, 32'h104);
    step();
    dREN = 0;
    fixed_lat = 1;
    @(negedge CLK);
    chk("abort_dwait", 32'(dwait), 32'd1);
    @(negedge CLK);
    chk("abort_idle_ramREN", 32'(ramREN), 32'd0);
    chk("abort_idle_dwait", 32'(dwait), 32'd1);
    @(negedge CLK);
    chk("abort_igrant", 32'(ramREN), 32'd1);
    chk("abort_iaddr", ramaddr, 32'h2080);
    wait_done(1'b0);
    iREN = 0;

    // ERROR for three cycles, then ACCESS: strobes held, single iwait pulse.
    fixed_lat = 3;
    force_err = 1;
    issue_i(32'h20C0, ival(32'h20C0));
    @(negedge CLK);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("err_ramREN", 32'(ramREN), 32'd1);
      chk("err_iwait", 32'(iwait), 32'd1);
    end
    @(negedge CLK);
    chk("err_done", 32'(iwait), 32'd0);
    step();
    iREN = 0;
    force_err = 0;
    @(negedge CLK);
    chk("err_single_pulse", 32'(iwait), 32'd1);
    chk("err_release", 32'(ramREN), 32'd0);
    step();

    // Asynchronous reset mid-access drops strobes at once.
    issue_i(32'h2100, ival(32'h2100));
    @(negedge CLK);
    @(negedge CLK);
    chk("arst_pre", 32'(ramREN), 32'd1);
    #1 nRST = 0;
    #1;
    chk("arst_ramREN", 32'(ramREN), 32'd0);
    chk("arst_iwait", 32'(iwait), 32'd1);
    void'(iexp.pop_back());
    iREN = 0;
    step();
    nRST = 1;
    step();

    // Randomised concurrent traffic with random latency and ERROR responses.
    fixed_lat = -1;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [31:0] a;
          repeat ($urandom_range(0, 3)) step();
          a = 32'h2000 + 32'(4 * $urandom_range(0, 63));
          issue_i(a, ival(a));
          wait_done(1'b0);
          iREN = 0;
        end
      end
      begin
        for (int n = 0; n < 60; n++) begin
          repeat ($urandom_range(0, 2)) step();
          issue_d(1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * $urandom_range(0, 15)),
                  $urandom, 1'($urandom_range(0, 1)), 1'b1);
          wait_done(1'b1);
          dREN = 0; dWEN = 0;
        end
      end
    join
    repeat (3) step();
    chk("sb_iexp_empty", 32'(iexp.size()), 32'd0);
    chk("sb_dexp_empty", 32'(dexp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
